ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a requester and the PS/2 host transmitter.
//   txData     [7:0] command byte, sampled when txStart is accepted
//   txStart          request strobe, accepted only while busy=0
//   busy             high from acceptance until done
//   done             one-cycle pulse at transfer end
//   ackErr           valid with done; 1 = device did not acknowledge
//   timeoutErr       valid with done; 1 = watchdog expired
// master = requester side, slave = ps2_host_tx side.
interface ps2_host_tx_if;
  logic [7:0] txData;
  logic       txStart;
  logic       busy;
  logic       done;
  logic       ackErr;
  logic       timeoutErr;

  modport master (
    output txData, txStart,
    input  busy, done, ackErr, timeoutErr
  );

  modport slave (
    input  txData, txStart,
    output busy, done, ackErr, timeoutErr
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (open-drain line control).
// Sequence: inhibit clock, request-to-send (start bit), 8 data bits LSB first,
// odd parity, stop bit, device acknowledge, wait for bus idle, done pulse.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        ps2_host_tx_if.slave (txData, txStart, busy, done, ackErr, timeoutErr)
//   PS2ClkIn   raw PS/2 clock level (asynchronous)
//   PS2DataIn  raw PS/2 data level (asynchronous)
//   PS2ClkOe   1 = pull PS/2 clock low, 0 = release
//   PS2DataOe  1 = pull PS/2 data low, 0 = release
// Optional feature: define PS2_TX_TIMEOUT_EN to enable the transfer watchdog
// (TIMEOUT_CYCLES). Without it timeoutErr is constant 0 and a silent device
// keeps the block busy until reset.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_host_tx_if.slave       bus,
  input  logic               PS2ClkIn,
  input  logic               PS2DataIn,
  output logic               PS2ClkOe,
  output logic               PS2DataOe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned SHF_W = 9;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, RELEASE, FINISH
  } state_t;

  state_t             state;
  logic [INH_W-1:0]   inh_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [SHF_W-1:0]   tx_shift;   // {parity, data}, shifted right as bits go out
  logic               ack_nok;
  logic               clk_s1, clk_s2, clk_s3;
  logic               dat_s1, dat_s2;
  logic               fall;

  // Device falling edge: synchronized clock was 1 last cycle and is 0 now.
  assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdog;
  logic            wd_active;
  assign wd_active = state inside {REQ, SHIFT, STOP, ACK, RELEASE};
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Synchronizers, transfer FSM and registered line/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      inh_cnt        <= '0;
      bit_cnt        <= '0;
      tx_shift       <= '0;
      ack_nok        <= 1'b0;
      clk_s1         <= 1'b1;
      clk_s2         <= 1'b1;
      clk_s3         <= 1'b1;
      dat_s1         <= 1'b1;
      dat_s2         <= 1'b1;
      PS2ClkOe       <= 1'b0;
      PS2DataOe      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ackErr     <= 1'b0;
      bus.timeoutErr <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdog           <= '0;
`endif
    end else begin
      clk_s1 <= PS2ClkIn;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2DataIn;
      dat_s2 <= dat_s1;

      // Status flags only carry meaning in the done cycle.
      bus.done       <= 1'b0;
      bus.ackErr     <= 1'b0;
      bus.timeoutErr <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.txStart) begin
            tx_shift  <= {~^bus.txData, bus.txData};
            bit_cnt   <= '0;
            inh_cnt   <= '0;
            ack_nok   <= 1'b0;
            bus.busy  <= 1'b1;
            PS2ClkOe  <= 1'b1;
            PS2DataOe <= 1'b0;
            state     <= INHIBIT;
          end
        end

        // Clock held low; device edges are ignored since the host owns the line.
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            PS2ClkOe  <= 1'b0;
            PS2DataOe <= 1'b1;
            state     <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        // First device edge clocks out data bit 0.
        REQ: begin
          if (fall) begin
            PS2DataOe <= ~tx_shift[0];
            tx_shift  <= {1'b0, tx_shift[SHF_W-1:1]};
            bit_cnt   <= BIT_W'(1);
            state     <= SHIFT;
          end
        end

        // Bits 1..7 then parity; bit_cnt==8 is the parity edge.
        SHIFT: begin
          if (fall) begin
            PS2DataOe <= ~tx_shift[0];
            tx_shift  <= {1'b0, tx_shift[SHF_W-1:1]};
            if (bit_cnt == BIT_W'(8)) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (fall) begin
            PS2DataOe <= 1'b0;
            state     <= ACK;
          end
        end

        ACK: begin
          if (fall) begin
            ack_nok <= dat_s2;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (clk_s2 && dat_s2) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.ackErr <= ack_nok;
            state      <= FINISH;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog restarts on every device edge; expiry overrides the FSM.
      if (!wd_active || fall) begin
        wdog <= '0;
      end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wdog           <= '0;
        PS2ClkOe       <= 1'b0;
        PS2DataOe      <= 1'b0;
        bus.busy       <= 1'b0;
        bus.done       <= 1'b1;
        bus.ackErr     <= 1'b0;
        bus.timeoutErr <= 1'b1;
        state          <= FINISH;
      end else begin
        wdog <= wdog + 1'b1;
      end
`endif
    end
  end

endmodule
